seven_segment_scanner: RTL and testbench
========================================

// Module: seven_segment_scanner
// PURPOSE
//  Multiplexed seven-segment driver clocked by the scan strobe from the frequency generator.
//  Detects rising edges of ScanCLK and steps one digit per edge. Decodes hex nibbles with a
//  decimal-point mask, blanks optional leading zeros and gaps anodes against ghosting.
//  Display data is latched once per frame, so values never tear mid-scan.
// PARAMETERS
//  DIGITS        8  number of multiplexed digits (2..16)
//  BLANK_CYCLES  4  InputCLK cycles all anodes stay off after each digit step (0 = no gap)
//  ACTIVE_LOW    1  1: Anodes/Segments/Dot active-low (board default); 0: active-high
// PORTS
//  InputCLK           in   1         system clock (100 MHz)
//  ResetN             in   1         synchronous, active-low reset
//  ScanCLK            in   1         slow square wave from frequency generator, same domain
//  Value              in   4*DIGITS  hex nibbles; [3:0] = digit 0 (rightmost)
//  DotMask            in   DIGITS    1 = light decimal point of that digit
//  BlankLeadingZeros  in   1         1 = suppress leading zero digits
//  Anodes             out  DIGITS    one-hot digit enable (polarity per ACTIVE_LOW)
//  Segments           out  7         {g,f,e,d,c,b,a} (polarity per ACTIVE_LOW)
//  Dot                out  1         decimal point (polarity per ACTIVE_LOW)
//  FrameDone          out  1         1-cycle pulse on each wrap of the digit index
// BEHAVIOUR
//  Reset (ResetN=0 at edge):
//   - ScanPrev=1, DigitIdx=DIGITS-1, BlankCnt=0, shadow Value/DotMask/Blank=0.
//   - All outputs inactive: Anodes/Segments/Dot at off level, FrameDone=0.
//   - Reset mid-scan is identical: all state is restored at the next edge.
//  Step:
//   - Step = ScanCLK & ~ScanPrev. ScanPrev <= ScanCLK every cycle.
//   - A level held high is one step; ScanCLK high out of reset gives no step.
//  On Step at edge k:
//   - DigitIdx <= (DigitIdx==DIGITS-1) ? 0 : DigitIdx+1.
//   - BlankCnt <= BLANK_CYCLES.
//  Wrap (Step with DigitIdx==DIGITS-1):
//   - Shadow regs load Value, DotMask, BlankLeadingZeros.
//   - FrameDone=1 for the cycle after edge k.
//   - The first step after reset is a wrap: it loads the shadow and pulses FrameDone.
//  BlankCnt: decrements by 1 per cycle while nonzero. A new Step reloads it even if nonzero.
//  Outputs: registered from DigitIdx, BlankCnt and shadow state.
//   - Digit lit iff BlankCnt==0 and not leading-blank.
//   - First lit cycle after a Step at edge k is at edge k+1+BLANK_CYCLES.
//   - Unlit: Anodes, Segments and Dot are all off.
//  Leading-zero blank: digit i (i>0) blanks iff shadow Blank=1, shadow nibbles i..DIGITS-1
//   are all 0, and shadow DotMask[i]=0. Digit 0 never blanks (value 0 shows "0").
//  Decode: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
//   (active-high {g..a}). ACTIVE_LOW inverts Anodes, Segments and Dot together.
//  Changes to Value/DotMask mid-frame take effect only at the next wrap.
// STRUCTURE
//  - Shared package/include: segment pattern constants, SEG_OFF/SEG_ON polarity helpers,
//    clog2 for DigitIdx width.
//  - Sub-module hex_to_seven_seg: 4-bit nibble -> 7-bit active-high pattern, combinational.
//  - Top holds edge detect, index counter, blank counter, shadow regs and output registers.
// TESTING (DIGITS=4, BLANK_CYCLES=2, ACTIVE_LOW=1 unless stated)
//  1 Reset with ScanCLK=1, hold 10 cycles -> Anodes=4'b1111, Segments=7'h7F, FrameDone=0;
//    no step.
//  2 Value=16'h12AF, one ScanCLK rise detected at edge k:
//    - FrameDone=1 after edge k only.
//    - Anodes=1111 after edges k+1 and k+2.
//    - Anodes=4'b1110 and Segments=7'h0E (F) after edge k+3.
//  3 Three further steps -> digits 1,2,3 give Anodes 1101/1011/0111 and Segments
//    7'h08 (A), 7'h24 (2), 7'h79 (1). The fifth step wraps with a FrameDone pulse.
//  4 Value=16'h0005, BlankLeadingZeros=1, DotMask=4'b0100:
//    - Digit 3 blank (Anodes 1111).
//    - Digit 2 lit with Segments=7'h40 (0) and Dot=0.
//    - Digit 0 shows 5 (7'h12).
//  5 Change Value 16'h1111->16'h2222 while DigitIdx=1 -> digits 2,3 still show 1;
//    the next frame shows 2.
//  6 Assert ResetN=0 for one edge while digit 2 is lit -> next cycle all outputs off,
//    DigitIdx=3; the next step displays digit 0. Repeat with BLANK_CYCLES=0 -> lit at edge k+1.

Source files
------------

// File: rtl/seven_segment_scanner_pkg.sv
// Shared definitions for the seven-segment scanner.
//  - SEG_TABLE: active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
//  - segOff / segOn: map "all segments dark" and an active-high pattern onto
//    the board polarity selected by ACTIVE_LOW.
//  - clog2: width helper for the digit index and blank counter.
package seven_segment_scanner_pkg;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] segOff(input bit activeLow);
    return activeLow ? 7'h7F : 7'h00;
  endfunction

  function automatic logic [6:0] segOn(input logic [6:0] pattern, input bit activeLow);
    return activeLow ? ~pattern : pattern;
  endfunction

  // Smallest r with 2**r >= n (0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seven_segment_scanner_hex.sv
// hex_to_seven_seg: combinational hex nibble to seven-segment decoder.
//  Nibble   in   4  hex value 0..F
//  Pattern  out  7  active-high {g,f,e,d,c,b,a}
module hex_to_seven_seg
  import seven_segment_scanner_pkg::*;
(
  input  logic [3:0] Nibble,
  output logic [6:0] Pattern
);

  assign Pattern = SEG_TABLE[Nibble];

endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: multiplexed seven-segment display driver.
//  Steps one digit on every rising edge of ScanCLK (a slow strobe in the
//  InputCLK domain), gaps all anodes for BLANK_CYCLES after each step to avoid
//  ghosting, suppresses optional leading zeros and latches display data once
//  per frame so a scan never shows a half-updated value.
// Ports:
//  InputCLK           in   1         system clock
//  ResetN             in   1         synchronous active-low reset
//  ScanCLK            in   1         scan strobe, same clock domain
//  Value              in   4*DIGITS  hex nibbles, [3:0] = digit 0 (rightmost)
//  DotMask            in   DIGITS    1 = light that digit's decimal point
//  BlankLeadingZeros  in   1         1 = suppress leading zero digits
//  Anodes             out  DIGITS    one-hot digit enable, polarity per ACTIVE_LOW
//  Segments           out  7         {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
//  Dot                out  1         decimal point, polarity per ACTIVE_LOW
//  FrameDone          out  1         one-cycle pulse per digit-index wrap
// Handshake: there is no back-pressure. FrameDone is a plain strobe, high for
// exactly the one cycle after the edge that wrapped the index and reloaded the
// shadow registers; consumers must sample it every cycle.
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int BLANK_CYCLES = 4,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                  InputCLK,
  input  logic                  ResetN,
  input  logic                  ScanCLK,
  input  logic [4*DIGITS-1:0]   Value,
  input  logic [DIGITS-1:0]     DotMask,
  input  logic                  BlankLeadingZeros,
  output logic [DIGITS-1:0]     Anodes,
  output logic [6:0]            Segments,
  output logic                  Dot,
  output logic                  FrameDone
);

  localparam int IDX_W   = clog2(DIGITS);
  localparam int BLANK_W = (BLANK_CYCLES > 0) ? clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DIGITS - 1);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES);
  localparam logic [DIGITS-1:0]  ANODES_OFF = {DIGITS{ACTIVE_LOW}};

  logic                  scanPrev;
  logic                  step;
  logic                  wrap;
  logic [IDX_W-1:0]      digitIdx;
  logic [BLANK_W-1:0]    blankCnt;
  logic [4*DIGITS-1:0]   shadowValue;
  logic [DIGITS-1:0]     shadowDot;
  logic                  shadowBlank;
  // Clear until the first wrap after reset: the shadow registers hold no real
  // data yet, so the display stays dark instead of showing a spurious "0".
  logic                  shadowValid;

  logic [DIGITS-1:0]     leadBlank;
  logic                  zeroSoFar;
  logic [3:0]            curNibble;
  logic                  curDot;
  logic                  curLead;
  logic [DIGITS-1:0]     anodeOneHot;
  logic [6:0]            curPattern;
  logic                  lit;

  assign step = ScanCLK & ~scanPrev;
  assign wrap = step & (digitIdx == LAST_IDX);

  // Leading-zero mask: walk from the most significant digit down, a digit
  // blanks while everything from it upward is zero and it has no dot lit.
  // Digit 0 is never blanked so an all-zero value still reads "0".
  always_comb begin
    leadBlank   = '0;
    zeroSoFar   = 1'b1;
    curNibble   = 4'h0;
    curDot      = 1'b0;
    curLead     = 1'b0;
    anodeOneHot = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zeroSoFar    = zeroSoFar & (shadowValue[i*4 +: 4] == 4'h0);
      leadBlank[i] = shadowBlank & zeroSoFar & ~shadowDot[i];
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (digitIdx == IDX_W'(i)) begin
        curNibble      = shadowValue[i*4 +: 4];
        curDot         = shadowDot[i];
        curLead        = leadBlank[i];
        anodeOneHot[i] = 1'b1;
      end
    end
  end

  assign lit = shadowValid & (blankCnt == '0) & ~curLead;

  hex_to_seven_seg u_decoder (
    .Nibble  (curNibble),
    .Pattern (curPattern)
  );

  always_ff @(posedge InputCLK) begin
    if (!ResetN) begin
      scanPrev    <= 1'b1;
      digitIdx    <= LAST_IDX;
      blankCnt    <= '0;
      shadowValue <= '0;
      shadowDot   <= '0;
      shadowBlank <= 1'b0;
      shadowValid <= 1'b0;
      Anodes      <= ANODES_OFF;
      Segments    <= segOff(ACTIVE_LOW);
      Dot         <= ACTIVE_LOW;
      FrameDone   <= 1'b0;
    end else begin
      scanPrev  <= ScanCLK;
      FrameDone <= wrap;

      // A new step restarts the anti-ghost gap even if it is still running.
      if (step) begin
        digitIdx <= (digitIdx == LAST_IDX) ? '0 : digitIdx + IDX_W'(1);
        blankCnt <= BLANK_LOAD;
      end else if (blankCnt != '0) begin
        blankCnt <= blankCnt - BLANK_W'(1);
      end

      if (wrap) begin
        shadowValue <= Value;
        shadowDot   <= DotMask;
        shadowBlank <= BlankLeadingZeros;
        shadowValid <= 1'b1;
      end

      Anodes   <= lit ? (anodeOneHot ^ ANODES_OFF) : ANODES_OFF;
      Segments <= lit ? segOn(curPattern, ACTIVE_LOW) : segOff(ACTIVE_LOW);
      Dot      <= (lit & curDot) ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner (DIGITS=4, ACTIVE_LOW=1).
// Instance dut uses BLANK_CYCLES=2, instance dut0 uses BLANK_CYCLES=0.
// Each output vector is {FrameDone, Anodes, Segments, Dot}. Stimulus pushes
// every expected change of that vector, tagged with the clock edge after
// which it must appear; the monitor pops an entry whenever the sampled vector
// changes and checks both value and edge number.
module tb_seven_segment_scanner;

  localparam int DIGITS = 4;
  localparam logic [12:0] OFF_VEC = {1'b0, 4'hF, 7'h7F, 1'b1};

  logic InputCLK = 1'b0;
  always #5 InputCLK = ~InputCLK;

  logic        ResetN, ResetN0, ScanCLK, ScanCLK0;
  logic [15:0] Value;
  logic [3:0]  DotMask;
  logic        BlankLeadingZeros;
  logic [3:0]  Anodes, Anodes0;
  logic [6:0]  Segments, Segments0;
  logic        Dot, Dot0, FrameDone, FrameDone0;

  seven_segment_scanner #(.DIGITS(DIGITS), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)) dut (
    .InputCLK(InputCLK), .ResetN(ResetN), .ScanCLK(ScanCLK), .Value(Value),
    .DotMask(DotMask), .BlankLeadingZeros(BlankLeadingZeros), .Anodes(Anodes),
    .Segments(Segments), .Dot(Dot), .FrameDone(FrameDone)
  );

  seven_segment_scanner #(.DIGITS(DIGITS), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b1)) dut0 (
    .InputCLK(InputCLK), .ResetN(ResetN0), .ScanCLK(ScanCLK0), .Value(Value),
    .DotMask(DotMask), .BlankLeadingZeros(BlankLeadingZeros), .Anodes(Anodes0),
    .Segments(Segments0), .Dot(Dot0), .FrameDone(FrameDone0)
  );

  int cycle = 0;
  always @(posedge InputCLK) cycle <= cycle + 1;

  int tests = 0;
  int fails = 0;
  logic [44:0] exp_q[$];
  logic [44:0] exp0_q[$];
  logic [12:0] lastExp [2];
  logic [12:0] lastSeen [2];

  // ---------------- scoreboard helpers ----------------
  task automatic expectAt(input int which, input int cyc, input logic [12:0] vec);
    logic [31:0] c;
    c = cyc;
    if (vec != lastExp[which]) begin
      if (which == 0) exp_q.push_back({c, vec});
      else            exp0_q.push_back({c, vec});
      lastExp[which] = vec;
    end
  endtask

  task automatic monitorOne(input int which, input logic [12:0] vec);
    logic [44:0] e;
    if (vec !== lastSeen[which]) begin
      lastSeen[which] = vec;
      tests++;
      if ((which == 0 && exp_q.size() == 0) || (which == 1 && exp0_q.size() == 0)) begin
        fails++;
        $display("FAIL unexpected_change dut%0d edge %0d: got %h, expected no change", which, cycle, vec);
      end else begin
        if (which == 0) e = exp_q.pop_front();
        else            e = exp0_q.pop_front();
        if (e[44:13] != cycle || e[12:0] !== vec)
          begin
            fails++;
            $display("FAIL output_change dut%0d: got %h at edge %0d, expected %h at edge %0d",
                     which, vec, cycle, e[12:0], e[44:13]);
          end
      end
    end
  endtask

  always @(negedge InputCLK) begin
    if (cycle >= 1) begin
      monitorOne(0, {FrameDone, Anodes, Segments, Dot});
      monitorOne(1, {FrameDone0, Anodes0, Segments0, Dot0});
    end
  end

  task automatic checkNow(input string name, input logic [12:0] got, input logic [12:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One ScanCLK rise; an/seg/dot describe the digit expected after the gap.
  task automatic doStep(input int which, input bit wrap, input logic [3:0] an,
                        input logic [6:0] seg, input logic dot);
    int k;
    int blank;
    logic [12:0] disp;
    blank = (which == 0) ? 2 : 0;
    @(negedge InputCLK);
    if (which == 0) ScanCLK = 1'b1;
    else            ScanCLK0 = 1'b1;
    k = cycle + 1;
    disp = {1'b0, an, seg, dot};
    expectAt(which, k, {wrap, lastExp[which][11:0]});
    if (blank > 0) expectAt(which, k + 1, OFF_VEC);
    expectAt(which, k + 1 + blank, disp);
    repeat (6) @(negedge InputCLK);
    if (which == 0) ScanCLK = 1'b0;
    else            ScanCLK0 = 1'b0;
    repeat (3) @(negedge InputCLK);
  endtask

  task automatic doReset(input int which);
    @(negedge InputCLK);
    if (which == 0) ResetN = 1'b0;
    else            ResetN0 = 1'b0;
    expectAt(which, cycle + 1, OFF_VEC);
    @(negedge InputCLK);
    if (which == 0) ResetN = 1'b1;
    else            ResetN0 = 1'b1;
    repeat (2) @(negedge InputCLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    lastExp[0] = OFF_VEC;  lastExp[1] = OFF_VEC;
    lastSeen[0] = OFF_VEC; lastSeen[1] = OFF_VEC;
    ResetN = 1'b0; ResetN0 = 1'b0;
    ScanCLK = 1'b1; ScanCLK0 = 1'b0;
    Value = 16'h0000; DotMask = 4'b0000; BlankLeadingZeros = 1'b0;

    // Reset with ScanCLK high, then release with it still high: no step.
    repeat (10) @(negedge InputCLK);
    checkNow("reset_outputs", {FrameDone, Anodes, Segments, Dot}, OFF_VEC);
    ResetN = 1'b1;
    repeat (5) @(negedge InputCLK);
    checkNow("no_step_after_reset", {FrameDone, Anodes, Segments, Dot}, OFF_VEC);
    ScanCLK = 1'b0;
    repeat (2) @(negedge InputCLK);

    // First frame of 12AF.
    Value = 16'h12AF;
    doStep(0, 1'b1, 4'b1110, 7'h0E, 1'b1);
    doStep(0, 1'b0, 4'b1101, 7'h08, 1'b1);
    doStep(0, 1'b0, 4'b1011, 7'h24, 1'b1);
    doStep(0, 1'b0, 4'b0111, 7'h79, 1'b1);

    // Leading-zero blanking with a dot holding digit 2 visible.
    Value = 16'h0005; BlankLeadingZeros = 1'b1; DotMask = 4'b0100;
    doStep(0, 1'b1, 4'b1110, 7'h12, 1'b1);
    doStep(0, 1'b0, 4'b1111, 7'h7F, 1'b1);
    doStep(0, 1'b0, 4'b1011, 7'h40, 1'b0);
    doStep(0, 1'b0, 4'b1111, 7'h7F, 1'b1);

    // Mid-frame value change waits for the next wrap.
    Value = 16'h1111; BlankLeadingZeros = 1'b0; DotMask = 4'b0000;
    doStep(0, 1'b1, 4'b1110, 7'h79, 1'b1);
    doStep(0, 1'b0, 4'b1101, 7'h79, 1'b1);
    Value = 16'h2222;
    doStep(0, 1'b0, 4'b1011, 7'h79, 1'b1);
    doStep(0, 1'b0, 4'b0111, 7'h79, 1'b1);
    doStep(0, 1'b1, 4'b1110, 7'h24, 1'b1);
    doStep(0, 1'b0, 4'b1101, 7'h24, 1'b1);
    doStep(0, 1'b0, 4'b1011, 7'h24, 1'b1);

    // Reset while digit 2 is lit; next step wraps to digit 0.
    doReset(0);
    doStep(0, 1'b1, 4'b1110, 7'h24, 1'b1);

    // Same with no anti-ghost gap.
    @(negedge InputCLK);
    ResetN0 = 1'b1;
    repeat (2) @(negedge InputCLK);
    doStep(1, 1'b1, 4'b1110, 7'h24, 1'b1);
    doStep(1, 1'b0, 4'b1101, 7'h24, 1'b1);
    doReset(1);
    doStep(1, 1'b1, 4'b1110, 7'h24, 1'b1);

    repeat (4) @(negedge InputCLK);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_dut: %0d expected changes never seen, expected 0", exp_q.size());
    end
    tests++;
    if (exp0_q.size() != 0) begin
      fails++;
      $display("FAIL pending_dut0: %0d expected changes never seen, expected 0", exp0_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
